// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encoding, interrupt codes, status/pending bit positions, mcause legality
package csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [31:0] IRQ_CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] IRQ_CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] IRQ_CAUSE_MEI = 32'h8000_000B;

    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

    function automatic logic mcause_legal(input logic [31:0] cause);
        logic [30:0] code;
        code = cause[30:0];
        if (cause[31]) begin
            return (code <= 31'd11) && (code != 31'd2) && (code != 31'd6) && (code != 31'd10);
        end
        return (code <= 31'd15) && (code != 31'd10) && (code != 31'd14);
    endfunction

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - free-running counter with independent 32-bit half writes
module csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_en,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wdata,
    output logic [CNT_WIDTH-1:0] value
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]          wide;

    // A write to either half wins over the increment for that cycle.
    always_comb begin
        wide  = 64'(cnt_q);
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) wide[31:0]  = wdata;
            if (wr_hi) wide[63:32] = wdata;
            cnt_d = wide[CNT_WIDTH-1:0];
        end else if (inc_en) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign value = cnt_q;

endmodule

// File: rtl/csr_trap_file.sv
// rtl/csr_trap_file.sv - M-mode CSR file with trap entry/return and interrupt arbitration; counters under CSR_COUNTERS_EN
module csr_trap_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          CNT_WIDTH   = 64
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  op,
    output logic [31:0] rdata,
    output logic        illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        retire,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic [31:0] trap_vector,
    output logic [31:0] epc,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic        ctrl_mie,
    output logic        ctrl_mpie
);

    csr_op_e op_e;
    assign op_e = csr_op_e'(op);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic [31:0] mstatus_rd, wr_val, tvec_base, irq_en;
    logic        csr_impl, csr_ro, eff_wr, csr_we;

`ifdef CSR_COUNTERS_EN
    logic [CNT_WIDTH-1:0] mcycle_val, minstret_val;
    logic [63:0]          mcycle_full, minstret_full;
    assign mcycle_full   = 64'(mcycle_val);
    assign minstret_full = 64'(minstret_val);

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk   (ctrl_clk),
        .rst_n (ctrl_reset_n),
        .inc_en(1'b1),
        .wr_lo (csr_we && (addr == CSR_MCYCLE)),
        .wr_hi (csr_we && (addr == CSR_MCYCLEH)),
        .wdata (wr_val),
        .value (mcycle_val)
    );

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk   (ctrl_clk),
        .rst_n (ctrl_reset_n),
        .inc_en(retire),
        .wr_lo (csr_we && (addr == CSR_MINSTRET)),
        .wr_hi (csr_we && (addr == CSR_MINSTRETH)),
        .wdata (wr_val),
        .value (minstret_val)
    );
`else
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = retire ^ (CNT_WIDTH < 32);
`endif

    always_comb begin
        mstatus_rd               = 32'h0000_1800;
        mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    end

    always_comb begin
        rdata    = '0;
        csr_impl = 1'b1;
        csr_ro   = 1'b0;
        case (addr)
            CSR_MSTATUS:  rdata = mstatus_rd;
            CSR_MISA:     begin rdata = MISA_VAL; csr_ro = 1'b1; end
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MIP:      rdata = mip_q;
            CSR_MHARTID:  begin rdata = HART_ID; csr_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata = mcycle_full[31:0];
            CSR_MCYCLEH:   rdata = mcycle_full[63:32];
            CSR_MINSTRET:  rdata = minstret_full[31:0];
            CSR_MINSTRETH: rdata = minstret_full[63:32];
            CSR_CYCLE:     begin rdata = mcycle_full[31:0];    csr_ro = 1'b1; end
            CSR_CYCLEH:    begin rdata = mcycle_full[63:32];   csr_ro = 1'b1; end
            CSR_INSTRET:   begin rdata = minstret_full[31:0];  csr_ro = 1'b1; end
            CSR_INSTRETH:  begin rdata = minstret_full[63:32]; csr_ro = 1'b1; end
`endif
            default:      csr_impl = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read and never counts as a write.
    always_comb begin
        case (op_e)
            OP_WRITE: wr_val = wdata;
            OP_SET:   wr_val = rdata | wdata;
            OP_CLEAR: wr_val = rdata & ~wdata;
            default:  wr_val = rdata;
        endcase
        eff_wr  = (op_e == OP_WRITE) || ((op_e != OP_NONE) && (wdata != 32'd0));
        illegal = (op_e != OP_NONE) && (!csr_impl || (eff_wr && csr_ro));
        csr_we  = eff_wr && csr_impl && !csr_ro && !trap_valid && !mret;
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mip_d          = '0;
        mip_d[MIP_MSIP] = irq_sw;
        mip_d[MIP_MTIP] = irq_timer;
        mip_d[MIP_MEIP] = irq_ext;
        if (trap_valid) begin
            mepc_d         = {trap_epc[31:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[MSTATUS_MIE];
                    mstatus_mpie_d = wr_val[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d = wr_val & MIE_WMASK;
                CSR_MTVEC:    if (wr_val[1:0] < 2'd2) mtvec_d = wr_val;
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d = {wr_val[31:2], 2'b00};
                CSR_MCAUSE:   if (mcause_legal(wr_val)) mcause_d = wr_val;
                CSR_MTVAL:    mtval_d = wr_val;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // Vectored mode only spreads interrupts; exceptions always land on the base.
    always_comb begin
        tvec_base   = {mtvec_q[31:2], 2'b00};
        trap_vector = tvec_base;
        if ((mtvec_q[1:0] == 2'b01) && trap_cause[31]) begin
            trap_vector = tvec_base + {trap_cause[29:0], 2'b00};
        end
    end

    always_comb begin
        irq_en      = mip_q & mie_q;
        irq_pending = mstatus_mie_q && (irq_en != 32'd0);
        irq_cause   = '0;
        if (irq_pending) begin
            if (irq_en[MIP_MEIP])      irq_cause = IRQ_CAUSE_MEI;
            else if (irq_en[MIP_MSIP]) irq_cause = IRQ_CAUSE_MSI;
            else                       irq_cause = IRQ_CAUSE_MTI;
        end
    end

    assign epc       = mepc_q;
    assign ctrl_mie  = mstatus_mie_q;
    assign ctrl_mpie = mstatus_mpie_q;

endmodule
